crtc_reg_loader: RTL and testbench
==================================

Name: crtc_reg_loader

Overview:
- Bus initiator that programs the 6845-style CRTC register file (R0–R15) over its CPU-side interface: ENABLE/nCS/R_nW/RS/DI/DO.
- Holds a 16x8 shadow table written by the host/OSD side, with one dirty bit per register.
- On request, writes dirty registers (or all registers) to the CRTC as address-then-data bus cycle pairs.
- Can align the burst to a VSYNC rising edge so mode changes land at a frame boundary.

Parameters:
GAP, 1, idle CLOCK cycles between consecutive bus cycles (0..15)

Ports:
CLOCK  in  1  system clock
nRESET  in  1  reset
tbl_we  in  1  shadow table write strobe
tbl_idx  in  4  shadow table index
tbl_data  in  8  shadow table write data
start  in  1  one-cycle request to begin a burst
full  in  1  sampled with start: 1 = write all 16 registers, 0 = dirty only
vs_align  in  1  sampled with start: 1 = wait for VSYNC_IN rising edge first
VSYNC_IN  in  1  CRTC VSYNC
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst end
err  out  1  sticky readback mismatch (optional feature)
dirty  out  16  dirty bitmap
crtc_enable  out  1  to CRTC ENABLE
crtc_ncs  out  1  to CRTC nCS
crtc_rnw  out  1  to CRTC R_nW
crtc_rs  out  1  to CRTC RS
crtc_di  out  8  to CRTC DI
crtc_do  in  8  from CRTC DO (combinational on CRTC side)

Behaviour:
- Reset: nRESET, synchronous, active-low; clock CLOCK.
- Reset values:
  - shadow table = 0, dirty = 0, busy = 0, done = 0, err = 0.
  - Bus idle: enable = 0, ncs = 1, rnw = 1, rs = 0, di = 0.
  - FSM = IDLE.
- Table write:
  - tbl_we writes shadow[tbl_idx] and sets dirty[tbl_idx] next cycle.
  - Legal in any state.
- States: IDLE, WAIT_VS, SCAN, ADDR, GAP_A, DATA, GAP_D, DONE.
- IDLE:
  - start latches full and vs_align; clears index i to 0.
  - Goes to WAIT_VS if vs_align = 1, else SCAN.
  - busy = 1 from the cycle after start until DONE inclusive.
  - start while busy is ignored.
- WAIT_VS: tracks previous VSYNC_IN; on rising edge goes to SCAN. No timeout.
- SCAN: one index per cycle.
  - If full_l or dirty[i], go to ADDR.
  - Else if i = 15, go to DONE; else i++.
- ADDR (exactly one cycle): enable = 1, ncs = 0, rnw = 0, rs = 0, di = {4'b0000, i}.
- GAP_A: bus idle for GAP cycles. GAP = 0 skips the state.
- DATA (exactly one cycle):
  - enable = 1, ncs = 0, rnw = 0, rs = 1, di = shadow[i] current value.
  - Clears dirty[i], except when tbl_we to i occurs in the same cycle; then dirty[i] stays set (the new value is written next burst).
- GAP_D: GAP idle cycles, then:
  - i = 15 → DONE.
  - Otherwise i++ → SCAN.
- DONE: done = 1 for one cycle; busy drops next cycle; return to IDLE.
- Bus outputs are registered. Every bus cycle is exactly one CLOCK cycle long and is bracketed by idle cycles when GAP ≥ 1.
- Cycle cost per written register = 3 + 2·GAP (SCAN + ADDR + DATA + gaps). Each skipped register costs 1.
- full = 1, GAP = 1, no vs_align: start at cycle 0 → done pulse at cycle 82.
  - 1 cycle IDLE→SCAN, 16×5 per register, DONE.
- Reset mid-burst aborts immediately. Bus returns to idle the same edge; a partially written register is not retried.

Optional Feature:
- Macro: CRTC_READBACK_EN.
- Defined:
  - After the DATA+GAP_D of i ∈ {10,11,14,15}, insert RB_ADDR (address cycle, as ADDR), then GAP, then RB_READ, then GAP.
  - RB_READ: enable = 1, ncs = 0, rnw = 1, rs = 1; crtc_do is sampled at the end of the cycle.
  - Compare under mask: R10 7'h7F, R11 5'h1F, R14 6'h3F, R15 8'hFF.
  - Mismatch sets err (sticky, cleared only by reset or by start).
- Undefined: no read cycles, err tied 0, timing as above.

Test Plan:
- Reset, then tbl_we idx 1 = 8'h28 and idx 6 = 8'h19, start full = 0 → exactly two ADDR/DATA pairs: di 0x01 then 0x28, di 0x06 then 0x19. dirty goes 0x0042 → 0x0000; done once.
- start full = 1, GAP = 1, shadow[i] = i+0x40 → 32 one-cycle bus writes in order 0..15. done at cycle 82 after start; ncs high between cycles.
- vs_align = 1, VSYNC_IN held low 500 cycles then high → no bus activity before the rising edge; first ADDR 2 cycles after the edge.
- tbl_we idx 6 = 8'h20 coinciding with DATA of idx 6 → di = 0x20 written, dirty[6] remains 1 after done.
- start asserted while busy, and nRESET asserted mid-burst → second start ignored; reset returns bus to idle next edge, busy = 0, dirty = 0.
- CRTC_READBACK_EN with CRTC model forcing DO = 0x00 for R15 when written 0xA5 → err = 1. All-matching burst leaves err = 0.

Source files
------------

// File: rtl/crtc_reg_loader.sv
// Programs a 6845-style CRTC register file from a 16x8 shadow table with per-register dirty bits.
// Optional macro CRTC_READBACK_EN adds readback verification of R10/R11/R14/R15 into a sticky err.

module crtc_reg_loader #(
  parameter int GAP = 1
) (
  input  logic        CLOCK,
  input  logic        nRESET,
  input  logic        tbl_we,
  input  logic [3:0]  tbl_idx,
  input  logic [7:0]  tbl_data,
  input  logic        start,
  input  logic        full,
  input  logic        vs_align,
  input  logic        VSYNC_IN,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] dirty,
  output logic        crtc_enable,
  output logic        crtc_ncs,
  output logic        crtc_rnw,
  output logic        crtc_rs,
  output logic [7:0]  crtc_di,
  input  logic [7:0]  crtc_do
);

  typedef enum logic [3:0] {
    IDLE, WAIT_VS, SCAN, ADDR, GAP_A, DATA, GAP_D, DONE
`ifdef CRTC_READBACK_EN
    , RB_ADDR, RB_GAP_A, RB_READ, RB_GAP_R
`endif
  } state_t;

  localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t      state_q, state_d;
  logic [3:0]  i_q, i_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        full_l_q, full_l_d;
  logic        vs_align_l_q, vs_align_l_d;
  logic        vs_prev_q, vs_prev_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] dirty_q, dirty_d;
  logic [7:0]  shadow_q [16];
  logic [7:0]  shadow_d [16];
  logic        enable_q, enable_d;
  logic        ncs_q, ncs_d;
  logic        rnw_q, rnw_d;
  logic        rs_q, rs_d;
  logic [7:0]  di_q, di_d;
  logic        gap_last;
  logic        after_data;
  logic        finish_reg;

  assign gap_last = (gap_cnt_q == GAP_LAST);

`ifdef CRTC_READBACK_EN
  logic       err_q, err_d;
  logic [7:0] rb_ref_q, rb_ref_d;
  logic [7:0] rb_mask;
  logic       rb_sel;

  assign rb_sel = (i_q == 4'd10) || (i_q == 4'd11) || (i_q == 4'd14) || (i_q == 4'd15);

  always_comb begin
    case (i_q)
      4'd10:   rb_mask = 8'h7F;
      4'd11:   rb_mask = 8'h1F;
      4'd14:   rb_mask = 8'h3F;
      default: rb_mask = 8'hFF;
    endcase
  end
  assign err = err_q;
`else
  logic unused_do;
  assign unused_do = ^crtc_do;
  assign err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    gap_cnt_d    = 4'd0;
    full_l_d     = full_l_q;
    vs_align_l_d = vs_align_l_q;
    vs_prev_d    = VSYNC_IN;
    busy_d       = busy_q;
    after_data   = 1'b0;
    finish_reg   = 1'b0;
    shadow_d     = shadow_q;
    if (tbl_we) shadow_d[tbl_idx] = tbl_data;
`ifdef CRTC_READBACK_EN
    err_d    = err_q;
    rb_ref_d = rb_ref_q;
`endif

    // IDLE spends one launch cycle (busy already high) before the burst proper.
    case (state_q)
      IDLE: begin
        if (busy_q) begin
          state_d = vs_align_l_q ? WAIT_VS : SCAN;
        end else if (start) begin
          full_l_d     = full;
          vs_align_l_d = vs_align;
          i_d          = 4'd0;
          busy_d       = 1'b1;
`ifdef CRTC_READBACK_EN
          err_d        = 1'b0;
`endif
        end
      end
      WAIT_VS: if (VSYNC_IN && !vs_prev_q) state_d = SCAN;
      SCAN: begin
        if (full_l_q || dirty_q[i_q]) state_d = ADDR;
        else if (i_q == 4'hF)         state_d = DONE;
        else                          i_d = i_q + 4'd1;
      end
      ADDR:  state_d = (GAP == 0) ? DATA : GAP_A;
      GAP_A: if (gap_last) state_d = DATA; else gap_cnt_d = gap_cnt_q + 4'd1;
      DATA:  if (GAP == 0) after_data = 1'b1; else state_d = GAP_D;
      GAP_D: if (gap_last) after_data = 1'b1; else gap_cnt_d = gap_cnt_q + 4'd1;
`ifdef CRTC_READBACK_EN
      RB_ADDR:  state_d = (GAP == 0) ? RB_READ : RB_GAP_A;
      RB_GAP_A: if (gap_last) state_d = RB_READ; else gap_cnt_d = gap_cnt_q + 4'd1;
      RB_READ: begin
        if (((crtc_do ^ rb_ref_q) & rb_mask) != 8'h00) err_d = 1'b1;
        if (GAP == 0) finish_reg = 1'b1; else state_d = RB_GAP_R;
      end
      RB_GAP_R: if (gap_last) finish_reg = 1'b1; else gap_cnt_d = gap_cnt_q + 4'd1;
`endif
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

`ifdef CRTC_READBACK_EN
    if (after_data) begin
      if (rb_sel) state_d = RB_ADDR;
      else        finish_reg = 1'b1;
    end
`else
    if (after_data) finish_reg = 1'b1;
`endif

    if (finish_reg) begin
      if (i_q == 4'hF) begin
        state_d = DONE;
      end else begin
        state_d = SCAN;
        i_d     = i_q + 4'd1;
      end
    end

    // A host write landing on the DATA launch edge keeps the register dirty.
    dirty_d = dirty_q;
    if (state_d == DATA) dirty_d[i_d] = 1'b0;
    if (tbl_we) dirty_d[tbl_idx] = 1'b1;

    enable_d = 1'b0;
    ncs_d    = 1'b1;
    rnw_d    = 1'b1;
    rs_d     = 1'b0;
    di_d     = 8'h00;
    case (state_d)
`ifdef CRTC_READBACK_EN
      ADDR, RB_ADDR: begin
`else
      ADDR: begin
`endif
        enable_d = 1'b1;
        ncs_d    = 1'b0;
        rnw_d    = 1'b0;
        di_d     = {4'b0000, i_d};
      end
      DATA: begin
        enable_d = 1'b1;
        ncs_d    = 1'b0;
        rnw_d    = 1'b0;
        rs_d     = 1'b1;
        di_d     = shadow_d[i_d];
`ifdef CRTC_READBACK_EN
        rb_ref_d = shadow_d[i_d];
`endif
      end
`ifdef CRTC_READBACK_EN
      RB_READ: begin
        enable_d = 1'b1;
        ncs_d    = 1'b0;
        rs_d     = 1'b1;
      end
`endif
      default: ;
    endcase

    done_d = (state_d == DONE);
  end

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      state_q      <= IDLE;
      i_q          <= 4'd0;
      gap_cnt_q    <= 4'd0;
      full_l_q     <= 1'b0;
      vs_align_l_q <= 1'b0;
      vs_prev_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dirty_q      <= 16'h0000;
      shadow_q     <= '{default: 8'h00};
      enable_q     <= 1'b0;
      ncs_q        <= 1'b1;
      rnw_q        <= 1'b1;
      rs_q         <= 1'b0;
      di_q         <= 8'h00;
`ifdef CRTC_READBACK_EN
      err_q        <= 1'b0;
      rb_ref_q     <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      gap_cnt_q    <= gap_cnt_d;
      full_l_q     <= full_l_d;
      vs_align_l_q <= vs_align_l_d;
      vs_prev_q    <= vs_prev_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dirty_q      <= dirty_d;
      shadow_q     <= shadow_d;
      enable_q     <= enable_d;
      ncs_q        <= ncs_d;
      rnw_q        <= rnw_d;
      rs_q         <= rs_d;
      di_q         <= di_d;
`ifdef CRTC_READBACK_EN
      err_q        <= err_d;
      rb_ref_q     <= rb_ref_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign dirty       = dirty_q;
  assign crtc_enable = enable_q;
  assign crtc_ncs    = ncs_q;
  assign crtc_rnw    = rnw_q;
  assign crtc_rs     = rs_q;
  assign crtc_di     = di_q;

endmodule

// File: tb/tb_crtc_reg_loader.sv
// Scoreboard bench for crtc_reg_loader: expected bus cycles are queued at start and popped per bus cycle.
// Honours CRTC_READBACK_EN the same way as the design.

module tb_crtc_reg_loader;

`ifdef CRTC_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int EXP_DONE_CYCLE = RB ? 98 : 82;

  logic        CLOCK = 1'b0;
  logic        nRESET = 1'b0;
  logic        tbl_we = 1'b0;
  logic [3:0]  tbl_idx = 4'h0;
  logic [7:0]  tbl_data = 8'h00;
  logic        start = 1'b0;
  logic        full = 1'b0;
  logic        vs_align = 1'b0;
  logic        VSYNC_IN = 1'b0;
  logic        busy, done, err;
  logic [15:0] dirty;
  logic        crtc_enable, crtc_ncs, crtc_rnw, crtc_rs;
  logic [7:0]  crtc_di, crtc_do;

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  int bus_cnt = 0;
  logic        prev_en = 1'b0;
  logic [9:0]  exp_q [$];
  logic [7:0]  sh [16];
  logic [15:0] dt_model = 16'h0000;
  logic [7:0]  crtc_regs [16];
  logic [3:0]  crtc_addr;

  crtc_reg_loader #(.GAP(1)) dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
    .start(start), .full(full), .vs_align(vs_align), .VSYNC_IN(VSYNC_IN),
    .busy(busy), .done(done), .err(err), .dirty(dirty),
    .crtc_enable(crtc_enable), .crtc_ncs(crtc_ncs), .crtc_rnw(crtc_rnw), .crtc_rs(crtc_rs),
    .crtc_di(crtc_di), .crtc_do(crtc_do)
  );

  always #5 CLOCK = ~CLOCK;

  // CRTC register model; R15 holding 0xA5 reads back as 0x00 to provoke a readback error.
  always @(posedge CLOCK) begin
    if (!nRESET) begin
      crtc_addr <= 4'h0;
      for (int k = 0; k < 16; k++) crtc_regs[k] <= 8'h00;
    end else if (crtc_enable && !crtc_ncs && !crtc_rnw) begin
      if (!crtc_rs) crtc_addr <= crtc_di[3:0];
      else          crtc_regs[crtc_addr] <= crtc_di;
    end
  end
  assign crtc_do = (crtc_addr == 4'hF && crtc_regs[15] == 8'hA5) ? 8'h00 : crtc_regs[crtc_addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; holds the inputs for exactly one sampling edge.
  task automatic applyStimulus(input logic we, input logic [3:0] idx, input logic [7:0] data,
                               input logic st, input logic fl, input logic va);
    tbl_we = we; tbl_idx = idx; tbl_data = data;
    start = st; full = fl; vs_align = va;
    if (we) begin
      sh[idx] = data;
      dt_model[idx] = 1'b1;
    end
    @(negedge CLOCK);
    tbl_we = 1'b0;
    start = 1'b0;
  endtask

  task automatic queueBurst(input logic fl);
    for (int k = 0; k < 16; k++) begin
      if (fl || dt_model[k]) begin
        exp_q.push_back({2'b00, 4'h0, 4'(k)});
        exp_q.push_back({2'b01, sh[k]});
        dt_model[k] = 1'b0;
        if (RB && (k == 10 || k == 11 || k == 14 || k == 15)) begin
          exp_q.push_back({2'b00, 4'h0, 4'(k)});
          exp_q.push_back({2'b11, 8'h00});
        end
      end
    end
  endtask

  task automatic waitDone(input int budget, input string tag);
    logic seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge CLOCK);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(tag, seen, 1);
  endtask

  // Bus monitor: every enabled cycle is popped against the scoreboard.
  initial begin
    forever begin
      @(negedge CLOCK);
      if (nRESET) begin
        if (done) done_cnt++;
        if (prev_en) checkOutput("gap_idle", {crtc_enable, crtc_ncs}, 2'b01);
        if (crtc_enable) begin
          bus_cnt++;
          checkOutput("ncs_low", crtc_ncs, 0);
          checkOutput("bus_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) checkOutput("bus_cycle", {crtc_rnw, crtc_rs, crtc_di}, exp_q.pop_front());
        end
        prev_en = crtc_enable;
      end else begin
        prev_en = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int done_base, bus_base, done_at, first_en;
    for (int k = 0; k < 16; k++) sh[k] = 8'h00;

    $display("[TB] reset");
    repeat (3) @(negedge CLOCK);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_dirty", dirty, 16'h0000);
    checkOutput("rst_bus", {crtc_enable, crtc_ncs, crtc_rnw, crtc_rs, crtc_di}, {4'b0110, 8'h00});
    nRESET = 1'b1;
    @(negedge CLOCK);

    $display("[TB] dirty-only burst");
    applyStimulus(1, 4'd1, 8'h28, 0, 0, 0);
    applyStimulus(1, 4'd6, 8'h19, 0, 0, 0);
    checkOutput("dirty_set", dirty, 16'h0042);
    queueBurst(0);
    done_base = done_cnt;
    applyStimulus(0, 4'd0, 8'h00, 1, 0, 0);
    checkOutput("busy_dirty_burst", busy, 1);
    waitDone(200, "done_dirty_burst");
    repeat (3) @(negedge CLOCK);
    checkOutput("dirty_cleared", dirty, 16'h0000);
    checkOutput("done_once", done_cnt - done_base, 1);
    checkOutput("queue_drained_1", exp_q.size(), 0);

    $display("[TB] full burst timing");
    for (int k = 0; k < 16; k++) applyStimulus(1, 4'(k), 8'(k + 8'h40), 0, 0, 0);
    queueBurst(1);
    done_base = done_cnt;
    start = 1'b1; full = 1'b1; vs_align = 1'b0;
    done_at = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge CLOCK);
      start = (k == 10);
      vs_align = (k == 10);
      if (k == 1) checkOutput("busy_after_start", busy, 1);
      if (done) begin
        done_at = k;
        break;
      end
    end
    start = 1'b0; vs_align = 1'b0;
    checkOutput("done_cycle", done_at, EXP_DONE_CYCLE);
    checkOutput("busy_at_done", busy, 1);
    @(negedge CLOCK);
    checkOutput("done_width", done, 0);
    checkOutput("busy_drop", busy, 0);
    checkOutput("full_done_once", done_cnt - done_base, 1);
    checkOutput("queue_drained_2", exp_q.size(), 0);
    checkOutput("dirty_after_full", dirty, 16'h0000);

    $display("[TB] vsync alignment");
    applyStimulus(1, 4'd0, 8'h55, 0, 0, 0);
    queueBurst(0);
    applyStimulus(0, 4'd0, 8'h00, 1, 0, 1);
    bus_base = bus_cnt;
    repeat (500) @(negedge CLOCK);
    checkOutput("vs_wait_busy", busy, 1);
    checkOutput("vs_no_bus", bus_cnt - bus_base, 0);
    VSYNC_IN = 1'b1;
    first_en = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLOCK);
      if (crtc_enable && first_en == 0) first_en = k;
    end
    checkOutput("vs_first_addr", first_en, 2);
    waitDone(200, "done_vs_burst");
    checkOutput("queue_drained_3", exp_q.size(), 0);

    $display("[TB] write colliding with data cycle");
    applyStimulus(1, 4'd6, 8'h11, 0, 0, 0);
    exp_q.push_back({2'b00, 8'h06});
    exp_q.push_back({2'b01, 8'h20});
    dt_model = 16'h0000;
    applyStimulus(0, 4'd0, 8'h00, 1, 0, 0);
    first_en = 0;
    for (int k = 0; k < 50; k++) begin
      if (crtc_enable && !crtc_rs && crtc_di == 8'h06) begin
        first_en = 1;
        break;
      end
      @(negedge CLOCK);
    end
    checkOutput("collide_addr_seen", first_en, 1);
    @(negedge CLOCK);
    applyStimulus(1, 4'd6, 8'h20, 0, 0, 0);
    waitDone(200, "done_collide");
    repeat (2) @(negedge CLOCK);
    checkOutput("collide_dirty_kept", dirty, 16'h0040);
    checkOutput("queue_drained_4", exp_q.size(), 0);

    $display("[TB] readback error flag");
    applyStimulus(1, 4'd15, 8'hA5, 0, 0, 0);
    queueBurst(0);
    applyStimulus(0, 4'd0, 8'h00, 1, 0, 0);
    waitDone(200, "done_rb_bad");
    checkOutput("err_bad", err, RB ? 1 : 0);
    applyStimulus(1, 4'd15, 8'h5A, 0, 0, 0);
    queueBurst(0);
    applyStimulus(0, 4'd0, 8'h00, 1, 0, 0);
    waitDone(200, "done_rb_good");
    checkOutput("err_good", err, 0);
    checkOutput("queue_drained_5", exp_q.size(), 0);

    $display("[TB] restart ignored and reset abort");
    queueBurst(1);
    applyStimulus(0, 4'd0, 8'h00, 1, 1, 0);
    repeat (8) @(negedge CLOCK);
    applyStimulus(0, 4'd0, 8'h00, 1, 0, 1);
    applyStimulus(1, 4'd12, 8'h77, 0, 0, 0);
    checkOutput("busy_before_reset", busy, 1);
    checkOutput("dirty12_before_reset", dirty[12], 1);
    nRESET = 1'b0;
    @(negedge CLOCK);
    checkOutput("abort_bus_idle", {crtc_enable, crtc_ncs, crtc_rnw, crtc_rs, crtc_di}, {4'b0110, 8'h00});
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_dirty", dirty, 16'h0000);
    exp_q.delete();
    for (int k = 0; k < 16; k++) sh[k] = 8'h00;
    dt_model = 16'h0000;
    @(negedge CLOCK);
    nRESET = 1'b1;
    @(negedge CLOCK);
    queueBurst(1);
    applyStimulus(0, 4'd0, 8'h00, 1, 1, 0);
    waitDone(300, "done_after_reset");
    checkOutput("queue_drained_6", exp_q.size(), 0);
    checkOutput("err_after_reset", err, 0);

    repeat (2) @(negedge CLOCK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
